// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared constants for the 16-bit CPU control path. Includes
//               opcode bit positions, ALU function codes, mux selects and
//               sequencer state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Bit positions within the decoder's one-hot opcode bus
    localparam int OP_NOP  = 0;
    localparam int OP_LD   = 1;
    localparam int OP_LN   = 2;
    localparam int OP_CP   = 3;
    localparam int OP_ST   = 4;
    localparam int OP_SHL  = 5;
    localparam int OP_ADD  = 6;
    localparam int OP_SUB  = 7;
    localparam int OP_JZ   = 8;
    localparam int OP_JB   = 9;
    localparam int OP_JMP  = 10;
    localparam int OP_XOR  = 11;
    localparam int OP_OR   = 12;
    localparam int OP_AND  = 13;
    localparam int OP_SHR  = 14;
    localparam int OP_NOT  = 15;
    localparam int OP_PUSH = 16;
    localparam int OP_POP  = 17;

    // ALU function codes
    localparam logic [3:0] ALU_PASS = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_SHL  = 4'd3;
    localparam logic [3:0] ALU_SHR  = 4'd4;
    localparam logic [3:0] ALU_AND  = 4'd5;
    localparam logic [3:0] ALU_OR   = 4'd6;
    localparam logic [3:0] ALU_XOR  = 4'd7;
    localparam logic [3:0] ALU_NOT  = 4'd8;

    // Address mux selects
    localparam logic [1:0] ADDR_PC  = 2'd0;
    localparam logic [1:0] ADDR_IMM = 2'd1;
    localparam logic [1:0] ADDR_SP  = 2'd2;

    // Accumulator source selects
    localparam logic [1:0] ACCSRC_ALU = 2'd0;
    localparam logic [1:0] ACCSRC_MEM = 2'd1;
    localparam logic [1:0] ACCSRC_BUS = 2'd2;

    // Sequencer states
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC1  = 3'd3;
    localparam logic [2:0] ST_EXEC2  = 3'd4;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_seq
// Description : Multi-cycle control sequencer. Walks IDLE/FETCH/DECODE/EXEC1/
//               EXEC2 and decodes every datapath strobe from the registered
//               state plus the decoder's one-hot opcode and the ALU flags.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_seq
    import cpu_pkg::*;
#(
    parameter int NUM_OPS  = 18,
    parameter int ALU_OP_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic [NUM_OPS-1:0]  op,
    input  logic                zf,
    input  logic                cf,
    output logic                iir,
    output logic                eir,
    output logic                mem_rd,
    output logic                mem_wr,
    output logic [1:0]          addr_sel,
    output logic                pc_inc,
    output logic                pc_load,
    output logic                acc_ld,
    output logic [1:0]          acc_src,
    output logic                acc_oe,
    output logic                b_ld,
    output logic                flags_ld,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                sp_inc,
    output logic                sp_dec,
    output logic                retired,
    output logic                illegal
);

    logic [2:0] r_state;
    logic [2:0] w_next;
    logic       w_legal;
    logic       w_two_cycle;

    // True when exactly one bit of the vector is set
    function automatic logic f_onehot(input logic [NUM_OPS-1:0] v);
        return (v != '0) && ((v & (v - NUM_OPS'(1))) == '0);
    endfunction

    // A malformed opcode is executed as a single-cycle nop
    assign w_legal     = f_onehot(op);
    assign w_two_cycle = w_legal & (op[OP_LD]  | op[OP_ADD] | op[OP_SUB] |
                                    op[OP_XOR] | op[OP_OR]  | op[OP_AND] |
                                    op[OP_PUSH] | op[OP_POP]);

    // Next-state selection; run is only consulted in IDLE and at instruction end
    always_comb begin
        w_next = ST_IDLE;
        case (r_state)
            ST_IDLE:   w_next = run ? ST_FETCH : ST_IDLE;
            ST_FETCH:  w_next = ST_DECODE;
            ST_DECODE: w_next = ST_EXEC1;
            ST_EXEC1:  w_next = w_two_cycle ? ST_EXEC2 : (run ? ST_FETCH : ST_IDLE);
            ST_EXEC2:  w_next = run ? ST_FETCH : ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Strobe decode from state, opcode and flags
    always_comb begin
        iir      = 1'b0;
        eir      = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        addr_sel = ADDR_PC;
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        acc_ld   = 1'b0;
        acc_src  = ACCSRC_ALU;
        acc_oe   = 1'b0;
        b_ld     = 1'b0;
        flags_ld = 1'b0;
        alu_op   = ALU_OP_W'(ALU_PASS);
        sp_inc   = 1'b0;
        sp_dec   = 1'b0;
        retired  = 1'b0;
        illegal  = 1'b0;
        case (r_state)
            ST_FETCH: begin
                mem_rd   = 1'b1;
                addr_sel = ADDR_PC;
                pc_inc   = 1'b1;
            end
            ST_DECODE: begin
                iir = 1'b1;
            end
            ST_EXEC1: begin
                retired = ~w_two_cycle;
                if (!w_legal) begin
                    illegal = 1'b1;
                end else begin
                    if (op[OP_LN]) begin
                        eir     = 1'b1;
                        acc_ld  = 1'b1;
                        acc_src = ACCSRC_BUS;
                    end
                    if (op[OP_CP]) begin
                        b_ld = 1'b1;
                    end
                    if (op[OP_ST]) begin
                        addr_sel = ADDR_IMM;
                        mem_wr   = 1'b1;
                        acc_oe   = 1'b1;
                    end
                    if (op[OP_SHL] | op[OP_SHR] | op[OP_NOT]) begin
                        acc_ld   = 1'b1;
                        acc_src  = ACCSRC_ALU;
                        flags_ld = 1'b1;
                        alu_op   = op[OP_SHL] ? ALU_OP_W'(ALU_SHL) :
                                   op[OP_SHR] ? ALU_OP_W'(ALU_SHR) :
                                                ALU_OP_W'(ALU_NOT);
                    end
                    if (op[OP_JMP] | op[OP_JZ] | op[OP_JB]) begin
                        eir     = 1'b1;
                        pc_load = op[OP_JMP] | (op[OP_JZ] & zf) | (op[OP_JB] & cf);
                    end
                    if (op[OP_LD] | op[OP_ADD] | op[OP_SUB] |
                        op[OP_XOR] | op[OP_OR] | op[OP_AND]) begin
                        addr_sel = ADDR_IMM;
                        mem_rd   = 1'b1;
                    end
                    if (op[OP_PUSH]) begin
                        sp_dec = 1'b1;
                    end
                    if (op[OP_POP]) begin
                        addr_sel = ADDR_SP;
                        mem_rd   = 1'b1;
                    end
                end
            end
            ST_EXEC2: begin
                retired = 1'b1;
                if (op[OP_LD]) begin
                    acc_ld  = 1'b1;
                    acc_src = ACCSRC_MEM;
                end
                if (op[OP_ADD] | op[OP_SUB] | op[OP_XOR] | op[OP_OR] | op[OP_AND]) begin
                    acc_ld   = 1'b1;
                    acc_src  = ACCSRC_ALU;
                    flags_ld = 1'b1;
                    alu_op   = op[OP_ADD] ? ALU_OP_W'(ALU_ADD) :
                               op[OP_SUB] ? ALU_OP_W'(ALU_SUB) :
                               op[OP_XOR] ? ALU_OP_W'(ALU_XOR) :
                               op[OP_OR]  ? ALU_OP_W'(ALU_OR)  :
                                            ALU_OP_W'(ALU_AND);
                end
                if (op[OP_PUSH]) begin
                    addr_sel = ADDR_SP;
                    mem_wr   = 1'b1;
                    acc_oe   = 1'b1;
                end
                if (op[OP_POP]) begin
                    acc_ld  = 1'b1;
                    acc_src = ACCSRC_MEM;
                    sp_inc  = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

endmodule : ctrl_seq
`default_nettype wire

// File: doc/ctrl_seq.md
Name:
ctrl_seq

Overview:
- Control sequencer of the 16-bit CPU; sits directly downstream of the instruction-register/decoder.
- Consumes the decoder's registered one-hot opcode lines, plus the ALU flags.
- Runs a multi-cycle IDLE/FETCH/DECODE/EXEC1/EXEC2 machine.
- Drives every datapath strobe, including the decoder's own iir (latch) and eir (drive immediate onto the data bus) inputs.

Parameters:
NUM_OPS, 18, width of one-hot opcode bus; fixed by ISA, not to be overridden
ALU_OP_W, 4, width of alu_op output

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous, active-high reset
run  in  1  1 = execute instructions; 0 = park in IDLE after current instruction
op  in  NUM_OPS  one-hot opcode from decoder; bit order nop,ld,ln,cp,st,shl,add,sub,jz,jb,jmp,xor,or,and,shr,not,push,pop = bit0..bit17
zf  in  1  ALU zero flag (registered in datapath)
cf  in  1  ALU borrow/below flag
iir  out  1  decoder latch enable
eir  out  1  decoder drives immediate onto data bus
mem_rd  out  1  memory read request (synchronous, data next cycle)
mem_wr  out  1  memory write strobe
addr_sel  out  2  address mux: 0=PC, 1=immediate, 2=SP
pc_inc  out  1  PC <= PC+1
pc_load  out  1  PC <= data bus
acc_ld  out  1  accumulator load
acc_src  out  2  acc source: 0=ALU, 1=memory, 2=data bus
acc_oe  out  1  accumulator drives data bus
b_ld  out  1  B register <= acc
flags_ld  out  1  zf/cf update
alu_op  out  ALU_OP_W  ALU function code
sp_inc  out  1  SP <= SP+1
sp_dec  out  1  SP <= SP-1
retired  out  1  1-cycle pulse in final cycle of each instruction
illegal  out  1  1-cycle pulse in EXEC1 when op is not exactly one-hot

Behaviour:
- Reset: state=IDLE. In IDLE every output is 0, so all outputs read 0 in the cycle after rst is sampled. rst mid-instruction abandons the instruction with no further strobes.
- Outputs are a combinational decode of the registered state, op, zf and cf. Unlisted outputs are 0 in every state.
- IDLE: go to FETCH when run=1; otherwise stay.
- FETCH: mem_rd=1, addr_sel=0, pc_inc=1. Next state DECODE.
- DECODE: iir=1 (code word valid this cycle). Next state EXEC1; op is valid from EXEC1 on.
- EXEC1, single-cycle ops:
  - nop: no strobes.
  - ln: eir, acc_ld, acc_src=2.
  - cp: b_ld.
  - st: addr_sel=1, mem_wr, acc_oe.
  - shl/shr/not: alu_op, acc_ld, acc_src=0, flags_ld.
  - jmp: eir, pc_load.
  - jz: eir, pc_load only if zf=1.
  - jb: eir, pc_load only if cf=1.
  - Illegal op is treated as nop and also pulses illegal.
- EXEC1, two-cycle ops:
  - ld/add/sub/xor/or/and: addr_sel=1, mem_rd.
  - push: sp_dec.
  - pop: addr_sel=2, mem_rd.
- EXEC2:
  - ld: acc_ld, acc_src=1.
  - add/sub/xor/or/and: alu_op, acc_ld, acc_src=0, flags_ld.
  - push: addr_sel=2, mem_wr, acc_oe.
  - pop: acc_ld, acc_src=1, sp_inc.
- retired=1 in the last exec cycle of every instruction.
- After the last exec cycle: go to FETCH if run=1, else IDLE. run is sampled only at that point and in IDLE; deasserting run mid-instruction never truncates it.
- CPI: 3 for single-cycle ops (not-taken jz/jb included), 4 for two-cycle ops.
- alu_op codes: PASS=0, ADD=1, SUB=2, SHL=3, SHR=4, AND=5, OR=6, XOR=7, NOT=8. Outside ALU cycles alu_op=0.
- mem_rd and mem_wr are never both 1. eir and acc_oe are never both 1 (bus contention).

Decomposition:
- Shared package cpu_pkg holds: opcode bit indices (OP_NOP..OP_POP), ALU_* codes, ADDR_PC/IMM/SP, ACCSRC_ALU/MEM/BUS, and the state enum.
- No sub-module; the one-hot validity check is a local function.

Test Plan:
- Reset then run=1, op=nop(bit0) → IDLE, FETCH(mem_rd=1,pc_inc=1), DECODE(iir=1), EXEC1(retired=1), FETCH; CPI=3.
- op=add(bit6) → EXEC1 addr_sel=1, mem_rd=1; EXEC2 alu_op=1, acc_ld=1, acc_src=0, flags_ld=1, retired=1; CPI=4.
- op=jz with zf=0 then zf=1 → pc_load=0 then 1; eir=1 in both EXEC1 cycles; CPI=3 in both.
- push then pop → push EXEC1 sp_dec=1, EXEC2 addr_sel=2/mem_wr/acc_oe; pop EXEC1 addr_sel=2/mem_rd, EXEC2 acc_ld/acc_src=1/sp_inc.
- op=18'h00041 (two bits set) → illegal=1 for one cycle in EXEC1, no other strobes, retired=1.
- run dropped during EXEC1 of ld, then rst asserted in a later DECODE → ld completes EXEC2 then IDLE; after rst all outputs 0, state IDLE.
